// File: rtl/fpu_pkg.sv
// fpu_pkg: FP32 width and elaboration helpers shared by FPU units
package fpu_pkg;
    localparam int FP32_W = 32;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant to the first requester at or after ptr, wrapping around
module rr_arbiter #(
    parameter int N = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    always_comb begin
        idx = '0;
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
        gnt = '0;
        if (|req) gnt[idx] = 1'b1;
    end
endmodule

// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: shares one pipelined FP32 multiplier among requesters; FP_MULT_ARB_FIXED_PRIO_EN selects fixed priority
module fp_mult_arbiter
    import fpu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TAG_W = 4,
    parameter int MULT_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*FP32_W-1:0]  req_a,
    input  logic [NUM_REQ*FP32_W-1:0]  req_b,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    output logic [NUM_REQ-1:0]         resp_valid,
    input  logic [NUM_REQ-1:0]         resp_ready,
    output logic [NUM_REQ*FP32_W-1:0]  resp_data,
    output logic [NUM_REQ*TAG_W-1:0]   resp_tag,
    output logic [FP32_W-1:0]          mul_a,
    output logic [FP32_W-1:0]          mul_b,
    input  logic [FP32_W-1:0]          mul_res
);
    localparam int ID_W = NUM_REQ > 1 ? clog2(NUM_REQ) : 1;
    typedef struct packed {
        logic             valid;
        logic [ID_W-1:0]  id;
        logic [TAG_W-1:0] tag;
    } pipe_t;
    logic [NUM_REQ-1:0] busy, gnt, rsp_hs;
    logic [ID_W-1:0] gidx, rr;
    logic issue;
    pipe_t pipe [MULT_LAT];
    pipe_t ex;
    rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
        .req(req_valid & ~busy),
        .ptr(rr),
        .gnt(gnt),
        .idx(gidx)
    );
    always_comb begin
        req_ready = rst_n ? gnt : '0;
        issue = |req_ready;
        mul_a = issue ? req_a[FP32_W*int'(gidx) +: FP32_W] : '0;
        mul_b = issue ? req_b[FP32_W*int'(gidx) +: FP32_W] : '0;
        rsp_hs = resp_valid & resp_ready;
        ex = pipe[MULT_LAT-1];
    end
`ifdef FP_MULT_ARB_FIXED_PRIO_EN
    assign rr = '0;
`else
    always_ff @(posedge clk)
        if (!rst_n) rr <= '0;
        else if (issue) rr <= gidx == ID_W'(NUM_REQ - 1) ? '0 : gidx + 1'b1;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
            resp_valid <= '0;
            resp_data <= '0;
            resp_tag <= '0;
            for (int k = 0; k < MULT_LAT; k++) pipe[k] <= '0;
        end else begin
            busy <= (busy | req_ready) & ~rsp_hs;
            pipe[0] <= {issue, gidx, req_tag[TAG_W*int'(gidx) +: TAG_W]};
            for (int k = 1; k < MULT_LAT; k++) pipe[k] <= pipe[k-1];
            resp_valid <= resp_valid & ~rsp_hs;
            if (ex.valid) begin
                resp_valid[ex.id] <= 1'b1;
                resp_data[FP32_W*int'(ex.id) +: FP32_W] <= mul_res;
                resp_tag[TAG_W*int'(ex.id) +: TAG_W] <= ex.tag;
            end
        end
    end
    // busy keeps a held result from being overwritten by its owner's next product
    assert property (@(posedge clk) disable iff (!rst_n) !(ex.valid && resp_valid[ex.id]));
endmodule
